// File: rtl/onset_detect_bank.sv
// Multi-band onset detector: rectify, leaky envelope, half-wave-rectified envelope
// difference and per-frame onset sums, one band per cycle through a shared datapath.
module onset_detect_bank #(
    parameter int unsigned W           = 8,
    parameter int unsigned NBANDS      = 6,
    parameter int unsigned ALPHA_SHIFT = 3,
    parameter int unsigned FRAME_LEN   = 64
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           ready,
    input  logic [NBANDS*W-1:0]                            bands_in,
    output logic [NBANDS*W-1:0]                            env_out,
    output logic [NBANDS*W-1:0]                            onset_out,
    output logic                                           sample_done,
    output logic [NBANDS*(W-1+$clog2(FRAME_LEN))-1:0]      frame_sum,
    output logic                                           frame_valid,
    output logic                                           busy,
    output logic                                           overrun
);

    localparam int unsigned FW = $clog2(FRAME_LEN);
    localparam int unsigned AW = W - 1 + FW;
    localparam int unsigned EW = W - 1 + ALPHA_SHIFT;
    localparam int unsigned VW = W - 1;
    localparam int unsigned IW = (NBANDS > 1) ? $clog2(NBANDS) : 1;
    localparam logic [W-1:0] XMIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_accept;
    logic            w_drop;
    logic            w_last_band;
    logic            w_frame_last;

    logic [NBANDS*W-1:0] r_hold;
    logic [IW-1:0]       r_idx;
    logic [FW-1:0]       r_cnt;

    logic [EW-1:0]   r_e        [NBANDS];
    logic [VW-1:0]   r_env_prev [NBANDS];
    logic [VW-1:0]   r_onset_stg[NBANDS];
    logic [AW-1:0]   r_acc      [NBANDS];
    logic [AW-1:0]   r_fsum_stg [NBANDS];

    logic [NBANDS*W-1:0]  r_env_out;
    logic [NBANDS*W-1:0]  r_onset_out;
    logic [NBANDS*AW-1:0] r_frame_sum;
    logic                 r_sample_done;
    logic                 r_frame_valid;
    logic                 r_busy;
    logic                 r_overrun;

    logic [W-1:0]    w_x;
    logic [EW-1:0]   w_e;
    logic [VW-1:0]   w_env_prev;
    logic [AW-1:0]   w_acc;
    logic [VW-1:0]   w_r;
    logic [EW-1:0]   w_e_new;
    logic [VW-1:0]   w_env_new;
    logic [W:0]      w_d;
    logic [VW-1:0]   w_onset;
    logic [AW-1:0]   w_acc_sum;

    assign w_last_band  = (r_idx == IW'(NBANDS - 1));
    assign w_frame_last = (r_cnt == FW'(FRAME_LEN - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a ready pulse outside IDLE is dropped and flagged
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (ready) begin
                    w_accept     = 1'b1;
                    w_state_next = PROC;
                end
            end
            PROC: begin
                w_drop = ready;
                if (w_last_band) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_drop       = ready;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Select the band currently being processed
    always_comb begin
        w_x        = '0;
        w_e        = '0;
        w_env_prev = '0;
        w_acc      = '0;
        for (int b = 0; b < NBANDS; b++) begin
            if (r_idx == IW'(b)) begin
                w_x        = r_hold[b*W +: W];
                w_e        = r_e[b];
                w_env_prev = r_env_prev[b];
                w_acc      = r_acc[b];
            end
        end
    end

    // Shared per-band datapath; E stays below 2^EW since it converges to r << ALPHA_SHIFT
    always_comb begin
        if (w_x == XMIN) begin
            w_r = '1;
        end else if (w_x[W-1]) begin
            w_r = (~w_x[VW-1:0]) + VW'(1);
        end else begin
            w_r = w_x[VW-1:0];
        end
        w_e_new   = w_e + EW'(w_r) - (w_e >> ALPHA_SHIFT);
        w_env_new = VW'(w_e_new >> ALPHA_SHIFT);
        w_d       = {2'b00, w_env_new} - {2'b00, w_env_prev};
        if (w_d[W] || (w_d == '0)) begin
            w_onset = '0;
        end else if (w_d[W-1]) begin
            w_onset = '1;
        end else begin
            w_onset = w_d[VW-1:0];
        end
        w_acc_sum = w_acc + AW'(w_onset);
    end

    // Capture, band index and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold    <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_busy <= (w_state_next != IDLE);
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
            if (w_accept) begin
                r_hold <= bands_in;
                r_idx  <= '0;
            end else if (r_state == PROC) begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

    // Per-band state, staged results and frame accumulation
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NBANDS; b++) begin
                r_e[b]         <= '0;
                r_env_prev[b]  <= '0;
                r_onset_stg[b] <= '0;
                r_acc[b]       <= '0;
                r_fsum_stg[b]  <= '0;
            end
        end else if (r_state == PROC) begin
            for (int b = 0; b < NBANDS; b++) begin
                if (r_idx == IW'(b)) begin
                    r_e[b]         <= w_e_new;
                    r_env_prev[b]  <= w_env_new;
                    r_onset_stg[b] <= w_onset;
                    if (w_frame_last) begin
                        r_fsum_stg[b] <= w_acc_sum;
                        r_acc[b]      <= '0;
                    end else begin
                        r_acc[b]      <= w_acc_sum;
                    end
                end
            end
        end
    end

    // All outputs publish together when the sample completes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_env_out     <= '0;
            r_onset_out   <= '0;
            r_frame_sum   <= '0;
            r_sample_done <= 1'b0;
            r_frame_valid <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_sample_done <= 1'b0;
            r_frame_valid <= 1'b0;
            if (r_state == DONE) begin
                r_sample_done <= 1'b1;
                r_cnt         <= r_cnt + FW'(1);
                for (int b = 0; b < NBANDS; b++) begin
                    r_env_out[b*W +: W]   <= {1'b0, r_env_prev[b]};
                    r_onset_out[b*W +: W] <= {1'b0, r_onset_stg[b]};
                end
                if (w_frame_last) begin
                    r_frame_valid <= 1'b1;
                    for (int b = 0; b < NBANDS; b++) begin
                        r_frame_sum[b*AW +: AW] <= r_fsum_stg[b];
                    end
                end
            end
        end
    end

    assign env_out     = r_env_out;
    assign onset_out   = r_onset_out;
    assign frame_sum   = r_frame_sum;
    assign sample_done = r_sample_done;
    assign frame_valid = r_frame_valid;
    assign busy        = r_busy;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_onset_detect_bank.sv
// Directed bench for onset_detect_bank: table of hand-computed samples plus
// sequences for latency/overrun, reset mid-sample and frame wrap.
module tb_onset_detect_bank;

    localparam int unsigned W  = 8;
    localparam int unsigned NB = 4;
    localparam int unsigned AS = 2;
    localparam int unsigned FL = 4;
    localparam int unsigned AW = 9;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 ready = 1'b0;
    logic [NB*W-1:0]      bands_in = '0;
    logic [NB*W-1:0]      env_out;
    logic [NB*W-1:0]      onset_out;
    logic                 sample_done;
    logic [NB*AW-1:0]     frame_sum;
    logic                 frame_valid;
    logic                 busy;
    logic                 overrun;

    onset_detect_bank #(
        .W(W), .NBANDS(NB), .ALPHA_SHIFT(AS), .FRAME_LEN(FL)
    ) dut (
        .clk(clk), .reset(reset), .ready(ready), .bands_in(bands_in),
        .env_out(env_out), .onset_out(onset_out), .sample_done(sample_done),
        .frame_sum(frame_sum), .frame_valid(frame_valid), .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] bands;
        logic [31:0] env;
        logic [31:0] onset;
        logic        fv;
        logic [35:0] fsum;
    } vec_t;

    vec_t tbl[10];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic logic [31:0] p8(input int a3, input int a2, input int a1, input int a0);
        return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [35:0] p9(input int a3, input int a2, input int a1, input int a0);
        return {9'(a3), 9'(a2), 9'(a1), 9'(a0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic rst, input logic [31:0] b, input logic [31:0] e,
                        input logic [31:0] o, input logic fv, input logic [35:0] fs);
        tbl[i].rst   = rst;
        tbl[i].bands = b;
        tbl[i].env   = e;
        tbl[i].onset = o;
        tbl[i].fv    = fv;
        tbl[i].fsum  = fs;
    endtask

    // Reset with ready held high to show it is ignored
    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        ready    = 1'b1;
        bands_in = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        ready    = 1'b0;
        bands_in = '0;
    endtask

    // One ready pulse, then wait (bounded) for sample_done; returns on that negedge
    task automatic send(input logic [31:0] b);
        logic got;
        @(negedge clk);
        bands_in = b;
        ready    = 1'b1;
        @(negedge clk);
        ready    = 1'b0;
        got      = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (sample_done) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: got no sample_done, expected one within 20 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        int n_done;
        int done_at;
        int fvs[3];
        int me, menv, mprev, md, mon, macc, mfs;
        logic mfv;

        setv(0, 1'b1, p8(0,0,0,64),       p8(0,0,0,16),  p8(0,0,0,16),  1'b0, p9(0,0,0,0));
        setv(1, 1'b0, p8(0,0,0,64),       p8(0,0,0,28),  p8(0,0,0,12),  1'b0, p9(0,0,0,0));
        setv(2, 1'b0, p8(0,0,0,64),       p8(0,0,0,37),  p8(0,0,0,9),   1'b0, p9(0,0,0,0));
        setv(3, 1'b0, p8(0,0,0,64),       p8(0,0,0,43),  p8(0,0,0,6),   1'b1, p9(0,0,0,43));
        setv(4, 1'b0, p8(0,0,0,0),        p8(0,0,0,33),  p8(0,0,0,0),   1'b0, p9(0,0,0,43));
        setv(5, 1'b1, p8(1,127,-128,0),   p8(0,31,31,0), p8(0,31,31,0), 1'b0, p9(0,0,0,0));
        setv(6, 1'b0, p8(1,127,0,0),      p8(0,55,24,0), p8(0,24,0,0),  1'b0, p9(0,0,0,0));
        setv(7, 1'b0, p8(1,127,0,0),      p8(0,73,18,0), p8(0,18,0,0),  1'b0, p9(0,0,0,0));
        setv(8, 1'b0, p8(1,127,0,0),      p8(1,87,13,0), p8(1,14,0,0),  1'b1, p9(1,87,31,0));
        setv(9, 1'b0, p8(1,-127,0,-1),    p8(1,97,10,0), p8(0,10,0,0),  1'b0, p9(1,87,31,0));

        do_reset();
        check("rst_env",   64'(env_out),     64'd0);
        check("rst_onset", 64'(onset_out),   64'd0);
        check("rst_fsum",  64'(frame_sum),   64'd0);
        check("rst_done",  64'(sample_done), 64'd0);
        check("rst_fv",    64'(frame_valid), 64'd0);
        check("rst_busy",  64'(busy),        64'd0);
        check("rst_ovr",   64'(overrun),     64'd0);

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rst) do_reset();
            send(tbl[i].bands);
            check($sformatf("v%0d_env", i),   64'(env_out),     64'(tbl[i].env));
            check($sformatf("v%0d_onset", i), 64'(onset_out),   64'(tbl[i].onset));
            check($sformatf("v%0d_fv", i),    64'(frame_valid), 64'(tbl[i].fv));
            check($sformatf("v%0d_fsum", i),  64'(frame_sum),   64'(tbl[i].fsum));
        end

        // Latency and overrun: second ready two cycles in must be dropped
        do_reset();
        n_done  = 0;
        done_at = -1;
        @(negedge clk);
        bands_in = p8(0,0,0,64);
        ready    = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            @(negedge clk);
            if (e == 0) begin
                ready = 1'b0;
                check("lat_busy", 64'(busy), 64'd1);
            end
            if (e == 1) begin
                check("ovr_before", 64'(overrun), 64'd0);
                ready    = 1'b1;
                bands_in = p8(0,0,0,127);
            end
            if (e == 2) begin
                ready = 1'b0;
                check("ovr_set", 64'(overrun), 64'd1);
            end
            if (sample_done) begin
                n_done++;
                done_at = e;
            end
        end
        check("lat_ndone", 64'(n_done), 64'd1);
        check("lat_edge",  64'(done_at), 64'(NB + 1));
        check("ovr_env",   64'(env_out), 64'(p8(0,0,0,16)));
        for (int s = 0; s < 3; s++) begin
            send(p8(0,0,0,0));
            fvs[s] = int'(frame_valid);
        end
        check("ovr_cnt_fv", 64'({fvs[0][0], fvs[1][0], fvs[2][0]}), 64'(3'b001));
        check("ovr_env2",   64'(env_out),   64'(p8(0,0,0,6)));
        check("ovr_fsum",   64'(frame_sum), 64'(p9(0,0,0,16)));
        check("ovr_sticky", 64'(overrun),   64'd1);

        // Reset two cycles into a sample aborts it
        @(negedge clk);
        bands_in = p8(0,0,0,64);
        ready    = 1'b1;
        n_done   = 0;
        for (int e = 0; e <= 12; e++) begin
            @(negedge clk);
            if (e == 0) ready = 1'b0;
            if (e == 1) reset = 1'b1;
            if (e == 2) reset = 1'b0;
            if (sample_done) n_done++;
        end
        check("mid_ndone", 64'(n_done),    64'd0);
        check("mid_env",   64'(env_out),   64'd0);
        check("mid_onset", 64'(onset_out), 64'd0);
        check("mid_fsum",  64'(frame_sum), 64'd0);
        check("mid_ovr",   64'(overrun),   64'd0);
        check("mid_busy",  64'(busy),      64'd0);
        send(p8(0,0,0,64));
        check("mid_first_env",   64'(env_out),   64'(p8(0,0,0,16)));
        check("mid_first_onset", 64'(onset_out), 64'(p8(0,0,0,16)));
        for (int s = 0; s < 3; s++) send(p8(0,0,0,64));
        check("mid_frame_fv",   64'(frame_valid), 64'd1);
        check("mid_frame_fsum", 64'(frame_sum),   64'(p9(0,0,0,43)));

        // Frame wrap over two frames against an integer model of band 2
        do_reset();
        me = 0; mprev = 0; macc = 0; mfs = 0;
        for (int s = 0; s < 8; s++) begin
            send(p8(0,127,0,0));
            me   = me + 127 - (me >>> AS);
            menv = me >>> AS;
            md   = menv - mprev;
            mon  = (md <= 0) ? 0 : ((md > 127) ? 127 : md);
            mprev = menv;
            macc = macc + mon;
            mfv  = ((s % 4) == 3);
            if (mfv) begin
                mfs  = macc;
                macc = 0;
            end
            check($sformatf("wrap%0d_env", s),   64'(env_out),     64'(p8(0,menv,0,0)));
            check($sformatf("wrap%0d_onset", s), 64'(onset_out),   64'(p8(0,mon,0,0)));
            check($sformatf("wrap%0d_fv", s),    64'(frame_valid), 64'(mfv));
            check($sformatf("wrap%0d_fsum", s),  64'(frame_sum),   64'(p9(0,mfs,0,0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/onset_detect_bank.md
ONSET_DETECT_BANK -- requirements
Module: onset_detect_bank

Interface
REQ-001 The block SHALL take these parameters: W, default 8, signed sample width.
REQ-002 The block SHALL take parameter NBANDS, default 6, number of band channels.
REQ-003 The block SHALL take parameter ALPHA_SHIFT, default 3, envelope leak shift (1..6).
REQ-004 The block SHALL take parameter FRAME_LEN, default 64, samples per frame (power of 2, >=2); AW = W-1+log2(FRAME_LEN).
REQ-005 The ports SHALL be:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- ready  in  1  one-cycle sample strobe.
- bands_in  in  NBANDS*W  packed signed samples, band 0 in LSBs.
- env_out  out  NBANDS*W  packed envelopes, non-negative.
- onset_out  out  NBANDS*W  packed half-wave-rectified envelope differences.
- sample_done  out  1  one-cycle pulse: env_out/onset_out updated.
- frame_sum  out  NBANDS*AW  packed unsigned per-band onset sums of the last completed frame.
- frame_valid  out  1  one-cycle pulse: frame_sum updated.
- busy  out  1  high while a sample is in process.
- overrun  out  1  sticky flag: a ready pulse was dropped.

Function
REQ-006 FSM SHALL have states IDLE, PROC, DONE; reset enters IDLE.
REQ-007 IDLE: ready=1 SHALL capture bands_in into a holding register, clear band index, and enter PROC.
REQ-008 PROC SHALL process one band per cycle, index 0..NBANDS-1, then enter DONE; DONE SHALL last one cycle and return to IDLE.
REQ-009 busy SHALL be 1 in PROC and DONE, 0 in IDLE.
REQ-010 Latency: ready sampled at edge t SHALL produce sample_done=1 for the cycle after edge t+NBANDS+1; next ready accepted one cycle later.
REQ-011 ready=1 while busy=1 SHALL be ignored (captured data, counters unchanged) and SHALL set overrun, cleared only by reset.
REQ-012 Rectify: r = |x|; x = -2^(W-1) SHALL give r = 2^(W-1)-1.
REQ-013 Envelope: per-band unsigned state E, W-1+ALPHA_SHIFT bits; E <= E + r - (E >> ALPHA_SHIFT); env = E >> ALPHA_SHIFT; E SHALL never overflow.
REQ-014 Difference: d = env_new - env_prev, W+1 bits signed; onset = d if d>0 else 0, saturated to 2^(W-1)-1; env_prev SHALL update to env_new.
REQ-015 env_out/onset_out SHALL update as one set in DONE, coincident with sample_done; no partial updates visible.
REQ-016 Sample counter SHALL count accepted samples 0..FRAME_LEN-1 and wrap to 0.
REQ-017 Per-band accumulator SHALL add onset each sample; on the sample with counter=FRAME_LEN-1, frame_sum SHALL load accumulator+onset, accumulator SHALL clear, frame_valid SHALL pulse with sample_done.
REQ-018 Accumulator width AW SHALL be sufficient; no saturation needed.

Reset
REQ-019 Reset SHALL override all activity, including mid-PROC: state IDLE, E, env_prev, accumulators, counters, holding register, all outputs to 0; no sample_done for the aborted sample.
REQ-020 ready coincident with reset SHALL be ignored.

Verification (W=8, NBANDS=4, ALPHA_SHIFT=2, FRAME_LEN=4)
REQ-021 Step: band0 = 64 on 4 ready pulses, spacing 8 -> env0 16,28,37,43; onset0 16,12,9,6; frame_valid on 4th with frame_sum0=43; other bands 0.
REQ-022 Negative full-scale: band1 = -128 once after reset -> E=127, env1=31, onset1=31.
REQ-023 Decay: after REQ-021, band0=0 for one sample -> env0 decreases, onset0=0.
REQ-024 Latency/overrun: ready at t and t+2 -> one sample_done at t+NBANDS+2, overrun=1 held until reset, counter advanced once.
REQ-025 Reset mid-PROC: reset at t+2 after ready -> no sample_done, all outputs 0; next ready behaves as first sample after reset.
REQ-026 Frame wrap: 8 samples, band2 = 127 -> frame_valid exactly after samples 4 and 8; sums match a reference model.
